mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 22 ++
 rtl/mem_access_ctrl_wait_timer.sv | 26 ++
 rtl/mem_access_ctrl.sv | 115 +++++++++++
 tb/tb_mem_access_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: default geometry,
// FSM state encoding and the address range helper.
package mem_access_ctrl_pkg;

  // Default RAM word-address width and ack wait limit.
  localparam int ADDR_W_DEF  = 9;
  localparam int TIMEOUT_DEF = 15;

  // FSM state encoding.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_WR_WAIT = 3'd2;
  localparam logic [2:0] S_RD_LOAD = 3'd3;
  localparam logic [2:0] S_FIN     = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  // True when every address bit above the RAM word range is zero.
  function automatic logic addr_in_range(input logic [31:0] addr, input int aw);
    return (addr >> aw) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// Ack wait counter: cleared while idle, counts unacknowledged wait cycles,
// flags the last allowed wait cycle.
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  // Count wait cycles; clear has priority over enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 8'd1;
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: turns single read/write requests from the
// control unit into a held-until-ack RAM handshake, loads read data into
// the MDR and reports completion, range/conflict errors and ack timeouts.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       mar_q,
  input  logic [31:0]       mdr_q,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       mdata_in,
  output logic              mdr_read,
  output logic              mdr_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  logic [2:0]        state, state_nx;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdata_r;
  logic              in_wait;
  logic              expired;
  logic              accept;

  assign in_wait = (state == S_RD_WAIT) || (state == S_WR_WAIT);
  // A clean request: exactly one of read/write, address inside the RAM.
  assign accept  = (state == S_IDLE) && (rd_req ^ wr_req) && addr_in_range(mar_q, ADDR_W);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state == S_IDLE),
    .enable  (in_wait && !mem_ack),
    .expired (expired)
  );

  // Next-state decode.
  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE: begin
        state_nx = S_IDLE;
        if (rd_req && wr_req)     state_nx = S_ERR;
        else if (accept)          state_nx = rd_req ? S_RD_WAIT : S_WR_WAIT;
        else if (rd_req || wr_req) state_nx = S_ERR;
      end
      S_RD_WAIT: begin
        state_nx = S_RD_WAIT;
        if (mem_ack)      state_nx = S_RD_LOAD;
        else if (expired) state_nx = S_ERR;
      end
      S_WR_WAIT: begin
        state_nx = S_WR_WAIT;
        if (mem_ack)      state_nx = S_FIN;
        else if (expired) state_nx = S_ERR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Address/write-data capture on an accepted request, so the RAM side
  // stays stable even if the MAR/MDR change during the wait.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (accept) begin
      addr_r <= mar_q[ADDR_W-1:0];
      if (wr_req) wdata_r <= mdq_sel(mdr_q);
    end
  end

  // Identity helper keeps the write-data capture explicit at 32 bits.
  function automatic logic [31:0] mdq_sel(input logic [31:0] d);
    return d;
  endfunction

  // Read data captured on the acknowledging cycle of a read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          rdata_r <= '0;
    else if (state == S_RD_WAIT && mem_ack) rdata_r <= mem_rdata;
  end

  // Outputs decoded from state or driven from registers only.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_RD_LOAD) || (state == S_FIN) || (state == S_ERR);
  assign err       = (state == S_ERR);
  assign mem_req   = in_wait;
  assign mem_we    = (state == S_WR_WAIT);
  assign mdr_read  = (state == S_RD_LOAD);
  assign mdr_in    = (state == S_RD_LOAD);
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mdata_in  = rdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural RAM responder.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int TO = TIMEOUT_DEF;

  logic          clock = 0;
  logic          reset_n;
  logic [31:0]   mar_q, mdr_q;
  logic          rd_req, wr_req;
  logic          busy, done, err;
  logic [31:0]   mdata_in;
  logic          mdr_read, mdr_in;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_req, mem_we;
  logic [31:0]   mem_rdata;
  logic          mem_ack;

  mem_access_ctrl dut (
    .clock(clock), .reset_n(reset_n), .mar_q(mar_q), .mdr_q(mdr_q),
    .rd_req(rd_req), .wr_req(wr_req), .busy(busy), .done(done), .err(err),
    .mdata_in(mdata_in), .mdr_read(mdr_read), .mdr_in(mdr_in),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_err;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
    int          reqs;
    int          start;
  } exp_t;

  exp_t        sb[$];
  int          cmp = 0, mism = 0;
  int          ncnt = 0, req_cycles = 0, mdr_pulses = 0, exp_reads = 0;
  logic [31:0] ram [0:(1<<AW)-1];
  int          ack_delay = 0, wait_n = 0;
  logic        no_ack = 0, stray_ack = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    if (got !== exp) begin
      mism++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // RAM model: acks after ack_delay wait cycles, or never when no_ack.
  always @(negedge clock) begin
    if (mem_req) begin
      if (!no_ack && wait_n == ack_delay) begin
        mem_ack = 1;
        if (mem_we) ram[mem_addr] = mem_wdata;
        else        mem_rdata = ram[mem_addr];
      end else begin
        mem_ack = 0;
        wait_n++;
      end
    end else begin
      mem_ack = stray_ack;
      mem_rdata = 32'hBAD0_BAD0;
      wait_n = 0;
    end
  end

  // Monitor: RAM-side stability and completion scoreboard.
  always @(negedge clock) begin
    exp_t e;
    ncnt++;
    if (mem_req) begin
      req_cycles++;
      if (sb.size() == 0) chk("req_unexpected", 1, 0);
      else begin
        chk("mem_we", mem_we, !sb[0].rd);
        chk("mem_addr", mem_addr, sb[0].addr & ((1 << AW) - 1));
        if (!sb[0].rd) chk("mem_wdata", mem_wdata, sb[0].data);
      end
    end
    if (mdr_in) mdr_pulses++;
    if (err && !done) chk("err_without_done", 1, 0);
    if (mdr_in && !done) chk("mdr_in_without_done", 1, 0);
    if (done) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("err", err, e.is_err);
        chk("latency", ncnt - e.start, e.lat);
        chk("req_cycles", req_cycles, e.reqs);
        chk("mdr_in", mdr_in, e.rd && !e.is_err);
        chk("mdr_read", mdr_read, e.rd && !e.is_err);
        if (e.rd && !e.is_err) chk("mdata_in", mdata_in, e.data);
      end
      req_cycles = 0;
    end
  end

  // Drive one request for one sampling edge; MAR/MDR are scrambled after.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic e, input int lat, input int reqs);
    exp_t x;
    rd_req = rd; wr_req = wr; mar_q = a;
    mdr_q  = (rd && !wr) ? $urandom : d;
    @(posedge clock);
    x.is_err = e; x.rd = rd && !wr; x.addr = a; x.data = d;
    x.lat = lat; x.reqs = reqs; x.start = ncnt;
    sb.push_back(x);
    if (x.rd && !e) exp_reads++;
    #1;
    rd_req = 0; wr_req = 0; mar_q = $urandom; mdr_q = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 1, 0);
      sb.delete();
    end
    #1;
    chk("idle_after", busy, 0);
  endtask

  initial begin
    logic [31:0] a, d;
    int          dl;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h5A00_0000 + i;
    ram[9'h010] = 32'hDEAD_BEEF;
    reset_n = 0; rd_req = 0; wr_req = 0; mar_q = 0; mdr_q = 0;
    mem_ack = 0; mem_rdata = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);    chk("rst_done", done, 0);
    chk("rst_err", err, 0);      chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0); chk("rst_mdr_in", mdr_in, 0);
    chk("rst_mdr_read", mdr_read, 0); chk("rst_mdata_in", mdata_in, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset_n = 1;
    @(posedge clock); #1;

    // Basic read, ack in first wait cycle.
    ack_delay = 0;
    issue(1, 0, 32'h10, 32'hDEAD_BEEF, 0, 2, 1); wait_done();

    // Write with three unacked wait cycles.
    ack_delay = 3;
    issue(0, 1, 32'h1F, 32'h1234_5678, 0, 5, 4); wait_done();
    chk("ram_1f", ram[9'h01F], 32'h1234_5678);
    ack_delay = 1;
    issue(1, 0, 32'h1F, 32'h1234_5678, 0, 3, 2); wait_done();

    // Ack never comes: full timeout then error.
    no_ack = 1;
    issue(1, 0, 32'h20, 32'h0, 1, TO + 1, TO); wait_done();
    no_ack = 0;

    // Out of range and conflicting requests.
    issue(1, 0, 32'h200, 32'h0, 1, 1, 0); wait_done();
    issue(0, 1, 32'h8000_0001, 32'h1, 1, 1, 0); wait_done();
    issue(1, 1, 32'h40, 32'h0, 1, 1, 0); wait_done();

    // Highest legal address.
    ack_delay = 2;
    issue(0, 1, 32'h1FF, 32'hCAFE_F00D, 0, 4, 3); wait_done();
    ack_delay = 0;
    issue(1, 0, 32'h1FF, 32'hCAFE_F00D, 0, 2, 1); wait_done();

    // Reset in the middle of a read wait.
    no_ack = 1;
    issue(1, 0, 32'h10, 32'hDEAD_BEEF, 0, 2, 1);
    exp_reads--;
    repeat (2) @(posedge clock);
    #2;
    reset_n = 0;
    #1;
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_busy", busy, 0);
    sb.delete();
    req_cycles = 0;
    @(posedge clock); #1;
    reset_n = 1; no_ack = 0;
    repeat (5) @(posedge clock);
    #1;
    chk("post_rst_busy", busy, 0);
    issue(1, 0, 32'h10, 32'hDEAD_BEEF, 0, 2, 1); wait_done();

    // Read request during a write wait is ignored.
    ack_delay = 4;
    issue(0, 1, 32'h33, 32'hA5A5_0F0F, 0, 6, 5);
    rd_req = 1; mar_q = 32'h44;
    @(posedge clock); #1;
    rd_req = 0;
    wait_done();
    chk("ram_33", ram[9'h033], 32'hA5A5_0F0F);

    // Stray ack while idle.
    stray_ack = 1;
    repeat (3) @(posedge clock);
    #1;
    stray_ack = 0;
    chk("stray_busy", busy, 0);
    repeat (2) @(posedge clock);
    #1;

    // Random write/readback pairs.
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range((1 << AW) - 1, 0);
      d = $urandom;
      dl = $urandom_range(5, 0);
      ack_delay = dl;
      issue(0, 1, a, d, 0, dl + 2, dl + 1); wait_done();
      dl = $urandom_range(5, 0);
      ack_delay = dl;
      issue(1, 0, a, d, 0, dl + 2, dl + 1); wait_done();
    end

    chk("mdr_pulses", mdr_pulses, exp_reads);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule
